// File: rtl/sms_io_multiport.sv
// SMS/GG-style controller I/O chip: NPORTS 7-pin ports with per-port TR/TH direction
// and output control, synchronised pads, TH edge interrupts (W1C) and a light-gun HV latch pulse.
module sms_io_multiport #(
    parameter int NPORTS      = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                MCLK,
    input  logic                rst,
    input  logic                cs_n,
    input  logic                rd_n,
    input  logic                wr_n,
    input  logic [3:0]          addr,
    input  logic [7:0]          data_i,
    output logic [7:0]          data_o,
    output logic                data_oe,
    input  logic [7*NPORTS-1:0] pin_i,
    output logic [7*NPORTS-1:0] pin_o,
    output logic [7*NPORTS-1:0] pin_d,
    output logic                irq_n,
    output logic                hv_latch
);

    localparam int PW = 7 * NPORTS;

    // CTRL bit positions
    localparam int C_TR_DIR = 0;
    localparam int C_TH_DIR = 1;
    localparam int C_TR_OUT = 2;
    localparam int C_TH_OUT = 3;
    localparam int C_IRQ_EN = 4;

    logic [SYNC_STAGES-1:0][PW-1:0] sync_q;
    logic [PW-1:0]                  pin_s;

    logic [NPORTS-1:0][4:0] ctrl_q, ctrl_d;
    logic [NPORTS-1:0]      pend_q, pend_d;
    logic [NPORTS-1:0]      th_prev_q, th_prev_d;
    logic                   hv_q, hv_d;

    logic [NPORTS-1:0]      th_eff, tr_eff, th_fall, th_rise;

    logic       wr_act, rd_act, wr_commit, rd_commit;
    logic       wr_blk_q, wr_hold_q, rd_blk_q, rd_hold_q;
    logic [3:0] wr_addr_q, rd_addr_q;
    logic [5:0] wr_dat_q;  // {data_i[7], data_i[4:0]}; bits 6:5 have no function
    logic       unused_dat;

    assign unused_dat = ^data_i[6:5];

    assign pin_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge MCLK) begin
        if (!rst) begin
            sync_q <= '1;
        end else begin
            sync_q[0] <= pin_i;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign wr_act    = ~cs_n & ~wr_n;
    assign rd_act    = ~cs_n & ~rd_n;
    assign wr_commit = wr_hold_q & ~wr_act;
    assign rd_commit = rd_hold_q & ~rd_act;

    // A strobe already active when reset releases stays blocked until it is seen inactive.
    always_ff @(posedge MCLK) begin
        if (!rst) begin
            wr_blk_q  <= 1'b1;
            wr_hold_q <= 1'b0;
            wr_addr_q <= '0;
            wr_dat_q  <= '0;
            rd_blk_q  <= 1'b1;
            rd_hold_q <= 1'b0;
            rd_addr_q <= '0;
        end else begin
            if (!wr_act) wr_blk_q <= 1'b0;
            if (!rd_act) rd_blk_q <= 1'b0;
            wr_hold_q <= wr_act & ~wr_blk_q;
            rd_hold_q <= rd_act & ~rd_blk_q;
            if (wr_act && !wr_blk_q) begin
                wr_addr_q <= addr;
                wr_dat_q  <= {data_i[7], data_i[4:0]};
            end
            if (rd_act && !rd_blk_q) begin
                rd_addr_q <= addr;
            end
        end
    end

    always_comb begin
        pin_o = '0;
        pin_d = '1;
        for (int p = 0; p < NPORTS; p++) begin
            th_eff[p]    = ctrl_q[p][C_TH_DIR] ? pin_s[7*p+6] : ctrl_q[p][C_TH_OUT];
            tr_eff[p]    = ctrl_q[p][C_TR_DIR] ? pin_s[7*p+4] : ctrl_q[p][C_TR_OUT];
            th_fall[p]   = th_prev_q[p] & ~th_eff[p];
            th_rise[p]   = ~th_prev_q[p] & th_eff[p];
            pin_o[7*p+4] = ctrl_q[p][C_TR_OUT];
            pin_o[7*p+6] = ctrl_q[p][C_TH_OUT];
            pin_d[7*p+4] = ctrl_q[p][C_TR_DIR];
            pin_d[7*p+6] = ctrl_q[p][C_TH_DIR];
        end
    end

    always_comb begin
        ctrl_d    = ctrl_q;
        pend_d    = pend_q;
        th_prev_d = th_eff;
        hv_d      = 1'b0;
        for (int p = 0; p < NPORTS; p++) begin
            if (wr_commit && wr_addr_q == 4'(2*p)) begin
                ctrl_d[p] = wr_dat_q[4:0];
            end
            if (wr_commit && wr_addr_q == 4'(2*p+1) && wr_dat_q[5]) begin
                pend_d[p] = 1'b0;
            end
            if (rd_commit && rd_addr_q == 4'(2*p+1)) begin
                pend_d[p] = 1'b0;
            end
            // Set is evaluated last so a coincident edge beats the clear.
            if (th_fall[p] && ctrl_q[p][C_TH_DIR] && ctrl_q[p][C_IRQ_EN]) begin
                pend_d[p] = 1'b1;
            end
            if (th_rise[p] && ctrl_q[p][C_TH_DIR]) begin
                hv_d = 1'b1;
            end
        end
    end

    always_ff @(posedge MCLK) begin
        if (!rst) begin
            ctrl_q    <= {NPORTS{5'h0F}};
            pend_q    <= '0;
            th_prev_q <= '1;
            hv_q      <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            pend_q    <= pend_d;
            th_prev_q <= th_prev_d;
            hv_q      <= hv_d;
        end
    end

    always_comb begin
        data_o = 8'hFF;
        for (int p = 0; p < NPORTS; p++) begin
            if (addr == 4'(2*p)) begin
                data_o = {3'b000, ctrl_q[p]};
            end
            if (addr == 4'(2*p+1)) begin
                data_o = {pend_q[p], th_eff[p], pin_s[7*p+5], tr_eff[p], pin_s[7*p +: 4]};
            end
        end
        if (addr == 4'(2*NPORTS)) begin
            data_o = 8'(pend_q);
        end
    end

    assign data_oe  = ~cs_n & ~rd_n;
    assign irq_n    = ~|pend_q;
    assign hv_latch = hv_q;

endmodule

// File: tb/tb_sms_io_multiport.sv
// Directed bench for sms_io_multiport (NPORTS=2, SYNC_STAGES=2); inputs driven and
// outputs sampled on the falling edge of MCLK.
module tb_sms_io_multiport;

    logic        MCLK = 1'b0;
    logic        rst;
    logic        cs_n, rd_n, wr_n;
    logic [3:0]  addr;
    logic [7:0]  data_i;
    logic [7:0]  data_o;
    logic        data_oe;
    logic [13:0] pin_i, pin_o, pin_d;
    logic        irq_n, hv_latch;

    int checks   = 0;
    int failures = 0;
    int hv_cnt   = 0;
    int hv_base;
    logic [7:0] rdat;
    logic       roe;

    always #5 MCLK = ~MCLK;

    always @(negedge MCLK) if (hv_latch === 1'b1) hv_cnt++;

    sms_io_multiport #(.NPORTS(2), .SYNC_STAGES(2)) dut (
        .MCLK(MCLK), .rst(rst), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n),
        .addr(addr), .data_i(data_i), .data_o(data_o), .data_oe(data_oe),
        .pin_i(pin_i), .pin_o(pin_o), .pin_d(pin_d),
        .irq_n(irq_n), .hv_latch(hv_latch)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge MCLK);
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
        cs_n = 1'b0; wr_n = 1'b0; addr = a; data_i = d;
        @(negedge MCLK);
        cs_n = 1'b1; wr_n = 1'b1;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [7:0] d, output logic oe);
        cs_n = 1'b0; rd_n = 1'b0; addr = a;
        @(negedge MCLK);
        d  = data_o;
        oe = data_oe;
        cs_n = 1'b1; rd_n = 1'b1;
    endtask

    initial begin
        rst = 1'b0; cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
        addr = 4'h0; data_i = 8'h00; pin_i = 14'h3FFF;
        cyc(3);
        rst = 1'b1;
        cyc(1);

        // Reset state
        chk("rst_irq_n", irq_n, 1'b1);
        chk("rst_hv", hv_latch, 1'b0);
        chk("rst_pin_d", pin_d, 14'h3FFF);
        chk("rst_pin_o", pin_o, 14'h2850);
        chk("idle_oe", data_oe, 1'b0);
        bus_read(4'h0, rdat, roe);
        chk("rst_ctrl0", rdat, 8'h0F);
        chk("rd_oe", roe, 1'b1);
        bus_read(4'h4, rdat, roe);
        chk("rst_status", rdat, 8'h00);

        // Port0: TR input, TH output low
        cyc(1);
        bus_write(4'h0, 8'h05);
        chk("wr_not_yet", pin_d[6], 1'b1);
        cyc(1);
        chk("wr_pin_d", pin_d, 14'h3FBF);
        chk("wr_pin_o", pin_o, 14'h2810);
        bus_read(4'h1, rdat, roe);
        chk("data0_th_out", rdat, 8'h3F);

        // Port1 TH falling edge interrupt
        cyc(1);
        bus_write(4'h2, 8'h1F);
        cyc(1);
        pin_i[13] = 1'b0;
        cyc(2);
        chk("irq_latency_early", irq_n, 1'b1);
        cyc(1);
        chk("irq_set", irq_n, 1'b0);
        bus_read(4'h4, rdat, roe);
        chk("status_pend1", rdat, 8'h02);
        bus_read(4'h3, rdat, roe);
        chk("data1_pend", rdat, 8'hBF);
        chk("irq_before_rd_clear", irq_n, 1'b0);
        cyc(1);
        chk("irq_after_rd_clear", irq_n, 1'b1);
        bus_read(4'h4, rdat, roe);
        chk("status_cleared", rdat, 8'h00);

        // Port0 TH as input: rising edge gives exactly one hv_latch pulse
        pin_i[6] = 1'b0;
        cyc(3);
        bus_write(4'h0, 8'h0F);
        cyc(3);
        hv_base = hv_cnt;
        pin_i[6] = 1'b1;
        cyc(2);
        chk("hv_early", hv_latch, 1'b0);
        cyc(1);
        chk("hv_pulse", hv_latch, 1'b1);
        cyc(1);
        chk("hv_one_cycle", hv_latch, 1'b0);
        cyc(4);
        chk("hv_held_no_repeat", hv_cnt, hv_base + 1);
        bus_write(4'h0, 8'h05);
        cyc(3);
        bus_write(4'h0, 8'h0D);
        cyc(4);
        chk("th_out_toggled", pin_o[6], 1'b1);
        chk("hv_output_mode", hv_cnt, hv_base + 1);

        // Coincident TH fall and W1C commit: set wins
        pin_i[13] = 1'b1;
        cyc(5);
        chk("pend_idle", irq_n, 1'b1);
        pin_i[13] = 1'b0;
        cyc(1);
        cs_n = 1'b0; wr_n = 1'b0; addr = 4'h3; data_i = 8'h80;
        cyc(1);
        cs_n = 1'b1; wr_n = 1'b1;
        cyc(1);
        chk("set_wins_irq", irq_n, 1'b0);
        bus_read(4'h4, rdat, roe);
        chk("set_wins_status", rdat, 8'h02);
        bus_write(4'h3, 8'h80);
        cyc(1);
        chk("w1c_clear", irq_n, 1'b1);

        // Reset in the middle of a write strobe
        cs_n = 1'b0; wr_n = 1'b0; addr = 4'h0; data_i = 8'h00;
        cyc(1);
        rst = 1'b0;
        cyc(2);
        rst = 1'b1;
        cyc(2);
        cs_n = 1'b1; wr_n = 1'b1;
        cyc(2);
        chk("rst_mid_pin_d", pin_d, 14'h3FFF);
        bus_read(4'h0, rdat, roe);
        chk("rst_mid_no_commit", rdat, 8'h0F);
        bus_read(4'hF, rdat, roe);
        chk("unmapped_F", rdat, 8'hFF);
        bus_read(4'h5, rdat, roe);
        chk("unmapped_5", rdat, 8'hFF);
        chk("rst_mid_irq_n", irq_n, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
